// File: rtl/scratch_result_harvester_if.sv
// Snoop, dump-stream and status bundle for scratch_result_harvester.
// The bench or CPU-side wrapper uses the master modport; the harvester uses the slave modport.
interface scratch_result_harvester_if #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 6
);
    logic              start;
    logic              spr_we;
    logic [ADDR_W-1:0] spr_addr;
    logic [DATA_W-1:0] spr_wdata;
    logic              dump_valid;
    logic              dump_ready;
    logic [ADDR_W-1:0] dump_addr;
    logic [DATA_W-1:0] dump_data;
    logic              dump_wr;
    logic              dump_last;
    logic              busy;
    logic              done;
    logic              timeout;
    logic              late_write;
    logic [DATA_W-1:0] checksum;

    modport master (
        output start, spr_we, spr_addr, spr_wdata, dump_ready,
        input  dump_valid, dump_addr, dump_data, dump_wr, dump_last,
        input  busy, done, timeout, late_write, checksum
    );

    modport slave (
        input  start, spr_we, spr_addr, spr_wdata, dump_ready,
        output dump_valid, dump_addr, dump_data, dump_wr, dump_last,
        output busy, done, timeout, late_write, checksum
    );
endinterface

// File: rtl/scratch_result_harvester.sv
// Shadows the scratchpad write port, waits for the sentinel write plus a settle delay, then streams it out.
// Optional feature macro HARVEST_CHECKSUM_EN: adds a running mod-2**DATA_W sum of dumped data.
module scratch_result_harvester #(
    parameter int DATA_W         = 8,
    parameter int ADDR_W         = 6,
    parameter int DEPTH          = 64,
    parameter int SENTINEL_ADDR  = DEPTH - 1,
    parameter int SETTLE_CYCLES  = 20,
    parameter int TIMEOUT_CYCLES = 65535
) (
    input  logic                        clk_i,
    input  logic                        reset_ni,
    scratch_result_harvester_if.slave   bus
);

    typedef enum logic [2:0] {IDLE, ARMED, SETTLE, DUMP, DONE} state_t;

    state_t              state_q, state_d;
    logic [DEPTH-1:0]    written_q, written_d;
    logic [DATA_W-1:0]   shadow_q [DEPTH];
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [31:0]         settle_q, settle_d;
    logic [31:0]         tmo_q, tmo_d;
    logic                done_q, done_d;
    logic                timeout_q, timeout_d;
    logic                late_q, late_d;

    logic in_range, snoop_en, sentinel_hit, handshake, is_last, idle_like, arm;

    assign idle_like    = (state_q == IDLE) || (state_q == DONE);
    assign arm          = idle_like && bus.start;
    assign in_range     = 32'(bus.spr_addr) < 32'(DEPTH);
    assign snoop_en     = bus.spr_we && in_range && ((state_q == ARMED) || (state_q == SETTLE));
    assign sentinel_hit = bus.spr_we && (bus.spr_addr == ADDR_W'(SENTINEL_ADDR));
    assign handshake    = (state_q == DUMP) && bus.dump_ready;
    assign is_last      = (addr_q == ADDR_W'(DEPTH - 1));

    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            state_q   <= IDLE;
            written_q <= '0;
            addr_q    <= '0;
            settle_q  <= '0;
            tmo_q     <= '0;
            done_q    <= 1'b0;
            timeout_q <= 1'b0;
            late_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            written_q <= written_d;
            addr_q    <= addr_d;
            settle_q  <= settle_d;
            tmo_q     <= tmo_d;
            done_q    <= done_d;
            timeout_q <= timeout_d;
            late_q    <= late_d;
        end
    end

    // Shadow contents are masked by the written bits, so the array itself needs no reset.
    always_ff @(posedge clk_i) begin
        if (snoop_en) begin
            shadow_q[bus.spr_addr] <= bus.spr_wdata;
        end
    end

    always_comb begin
        state_d   = state_q;
        written_d = written_q;
        addr_d    = addr_q;
        settle_d  = settle_q;
        tmo_d     = tmo_q;
        done_d    = done_q;
        timeout_d = timeout_q;
        late_d    = late_q;

        if (snoop_en) begin
            written_d[bus.spr_addr] = 1'b1;
        end

        case (state_q)
            IDLE, DONE: begin
                if (bus.start) begin
                    state_d   = ARMED;
                    written_d = '0;
                    addr_d    = '0;
                    settle_d  = '0;
                    tmo_d     = '0;
                    done_d    = 1'b0;
                    timeout_d = 1'b0;
                    late_d    = 1'b0;
                end
            end
            ARMED: begin
                tmo_d = tmo_q + 32'd1;
                if (sentinel_hit) begin
                    state_d  = SETTLE;
                    settle_d = '0;
                end else if ((TIMEOUT_CYCLES != 0) && (tmo_q == 32'(TIMEOUT_CYCLES - 1))) begin
                    state_d   = DONE;
                    timeout_d = 1'b1;
                end
            end
            SETTLE: begin
                if (settle_q == 32'(SETTLE_CYCLES - 1)) begin
                    state_d = DUMP;
                    addr_d  = '0;
                end else begin
                    settle_d = settle_q + 32'd1;
                end
            end
            DUMP: begin
                if (bus.spr_we) begin
                    late_d = 1'b1;
                end
                if (handshake) begin
                    if (is_last) begin
                        state_d = DONE;
                        done_d  = 1'b1;
                    end else begin
                        addr_d = addr_q + 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign bus.dump_valid = (state_q == DUMP);
    assign bus.dump_addr  = bus.dump_valid ? addr_q : '0;
    assign bus.dump_wr    = bus.dump_valid && written_q[addr_q];
    assign bus.dump_data  = bus.dump_wr ? shadow_q[addr_q] : '0;
    assign bus.dump_last  = bus.dump_valid && is_last;
    assign bus.busy       = (state_q == ARMED) || (state_q == SETTLE) || (state_q == DUMP);
    assign bus.done       = done_q;
    assign bus.timeout    = timeout_q;
    assign bus.late_write = late_q;

`ifdef HARVEST_CHECKSUM_EN
    logic [DATA_W-1:0] csum_q;

    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            csum_q <= '0;
        end else if (arm) begin
            csum_q <= '0;
        end else if (handshake) begin
            csum_q <= csum_q + bus.dump_data;
        end
    end

    assign bus.checksum = csum_q;
`else
    logic unused_arm;
    assign unused_arm   = arm;
    assign bus.checksum = '0;
`endif

endmodule

// File: tb/tb_scratch_result_harvester.sv
// Directed bench for scratch_result_harvester: inputs change and outputs are sampled on the falling edge.
// Built with or without HARVEST_CHECKSUM_EN; the expected checksum follows the same macro.
module tb_scratch_result_harvester;

    logic clk;
    logic reset_n;
    int   checks;
    int   errors;

    logic [7:0] modelMem [64];
    logic       modelWr  [64];

    scratch_result_harvester_if #(.DATA_W(8), .ADDR_W(6)) bus ();

    scratch_result_harvester #(.TIMEOUT_CYCLES(100)) dut (
        .clk_i    (clk),
        .reset_ni (reset_n),
        .bus      (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        if (observed !== expected) begin
            errors++;
            $display("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    // One-cycle snoop write; the model only tracks in-range addresses, as the harvester does.
    task automatic applyStimulus(input logic [5:0] addr, input logic [7:0] data);
        bus.spr_we    = 1'b1;
        bus.spr_addr  = addr;
        bus.spr_wdata = data;
        modelMem[addr] = data;
        modelWr[addr]  = 1'b1;
        @(negedge clk);
        bus.spr_we = 1'b0;
    endtask

    task automatic startPulse();
        for (int i = 0; i < 64; i++) modelWr[i] = 1'b0;
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
    endtask

    task automatic waitDump();
        int n;
        n = 0;
        checkOutput("settleBusy", bus.busy, 1);
        while (!bus.dump_valid && n < 200) begin
            @(negedge clk);
            n++;
        end
        checkOutput("settleLen", n, 20);
    endtask

    task automatic runDump(input int mode, input bit lateWrite);
        int         beat;
        int         cyc;
        logic       rdy;
        logic [7:0] sum;
        logic [7:0] expData;
        beat = 0;
        cyc  = 0;
        sum  = 8'h00;
        while (beat < 64 && cyc < 1000) begin
            rdy = (mode == 0) ? 1'b1 : (cyc % 3 == 2);
            if (lateWrite && cyc == 5) begin
                bus.spr_we    = 1'b1;
                bus.spr_addr  = 6'd7;
                bus.spr_wdata = 8'hEE;
            end else begin
                bus.spr_we = 1'b0;
            end
            if (bus.dump_valid) begin
                expData = modelWr[beat] ? modelMem[beat] : 8'h00;
                checkOutput("dumpAddr", bus.dump_addr, beat);
                checkOutput("dumpData", bus.dump_data, expData);
                checkOutput("dumpWr", bus.dump_wr, modelWr[beat]);
                checkOutput("dumpLast", bus.dump_last, beat == 63);
                if (rdy) begin
                    sum = sum + expData;
                    beat++;
                end
            end
            bus.dump_ready = rdy;
            @(negedge clk);
            cyc++;
        end
        bus.dump_ready = 1'b0;
        bus.spr_we     = 1'b0;
        checkOutput("dumpBeats", beat, 64);
        if (mode == 0) checkOutput("dumpCycles", cyc, 64);
        checkOutput("doneFlag", bus.done, 1);
        checkOutput("doneBusy", bus.busy, 0);
        checkOutput("doneValid", bus.dump_valid, 0);
        checkOutput("lateWrite", bus.late_write, lateWrite);
`ifdef HARVEST_CHECKSUM_EN
        checkOutput("checksum", bus.checksum, sum);
`else
        checkOutput("checksum", bus.checksum, 0);
`endif
    endtask

    initial begin
        int n;
        bit sawValid;
        checks         = 0;
        errors         = 0;
        reset_n        = 1'b0;
        bus.start      = 1'b0;
        bus.spr_we     = 1'b0;
        bus.spr_addr   = '0;
        bus.spr_wdata  = '0;
        bus.dump_ready = 1'b0;
        for (int i = 0; i < 64; i++) begin
            modelMem[i] = 8'h00;
            modelWr[i]  = 1'b0;
        end

        repeat (3) @(negedge clk);
        checkOutput("rstBusy", bus.busy, 0);
        checkOutput("rstDone", bus.done, 0);
        checkOutput("rstTimeout", bus.timeout, 0);
        checkOutput("rstValid", bus.dump_valid, 0);
        checkOutput("rstLate", bus.late_write, 0);
        checkOutput("rstChecksum", bus.checksum, 0);
        reset_n = 1'b1;
        @(negedge clk);

        $display("[TB] full pattern, ready held high");
        startPulse();
        for (int a = 0; a < 64; a++) applyStimulus(6'(a), 8'(a) ^ 8'hA5);
        waitDump();
        checkOutput("beat0Data", bus.dump_data, 8'hA5);
        runDump(0, 1'b0);
        checkOutput("beat63Model", modelMem[63], 8'h9A);

        $display("[TB] ready accepted one cycle in three");
        startPulse();
        for (int a = 0; a < 64; a++) applyStimulus(6'(a), 8'(a * 3 + 1));
        waitDump();
        runDump(1, 1'b0);

        $display("[TB] sparse writes");
        startPulse();
        applyStimulus(6'd5, 8'h3C);
        applyStimulus(6'd63, 8'h01);
        waitDump();
        runDump(0, 1'b0);

        $display("[TB] uniform data with a late snoop write");
        startPulse();
        for (int a = 0; a < 64; a++) applyStimulus(6'(a), 8'h04);
        waitDump();
        runDump(0, 1'b1);

        $display("[TB] reset during dump");
        startPulse();
        applyStimulus(6'd63, 8'h11);
        waitDump();
        bus.dump_ready = 1'b1;
        repeat (10) @(negedge clk);
        checkOutput("abortAddr", bus.dump_addr, 10);
        reset_n = 1'b0;
        #1;
        checkOutput("abortValid", bus.dump_valid, 0);
        checkOutput("abortBusy", bus.busy, 0);
        checkOutput("abortDone", bus.done, 0);
        bus.dump_ready = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        checkOutput("idleBusy", bus.busy, 0);
        checkOutput("idleValid", bus.dump_valid, 0);

        $display("[TB] timeout without sentinel");
        startPulse();
        n        = 0;
        sawValid = 1'b0;
        while (bus.busy && n < 300) begin
            if (bus.dump_valid) sawValid = 1'b1;
            @(negedge clk);
            n++;
        end
        checkOutput("timeoutLen", n, 100);
        checkOutput("timeoutFlag", bus.timeout, 1);
        checkOutput("timeoutDone", bus.done, 0);
        checkOutput("timeoutNoDump", sawValid, 0);

        $display("[TB] re-arm, sentinel on the final armed cycle");
        startPulse();
        checkOutput("rearmTimeout", bus.timeout, 0);
        checkOutput("rearmBusy", bus.busy, 1);
        repeat (99) @(negedge clk);
        checkOutput("lastArmedBusy", bus.busy, 1);
        applyStimulus(6'd63, 8'h55);
        checkOutput("sentinelWinsTimeout", bus.timeout, 0);
        waitDump();
        runDump(0, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
